// File: rtl/hazard_forward_if.sv
// Decode-stage / hazard-unit bundle: D-stage operand info in, stall and X forwarding selects out.
interface hazard_forward_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FSEL_W = 2,
  parameter int unsigned CNT_W  = 32
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic              d_use_rs1;
  logic              d_use_rs2;
  logic [REG_AW-1:0] d_rd;
  logic              d_wen;
  logic              d_is_load;
  logic              flush;
  logic              dmem_busy;
  logic              stall;
  logic              x_valid;
  logic [FSEL_W-1:0] fwd_a_sel;
  logic [FSEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen, d_is_load, flush, dmem_busy,
    input  stall, x_valid, fwd_a_sel, fwd_b_sel, stall_cycles
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen, d_is_load, flush, dmem_busy,
    output stall, x_valid, fwd_a_sel, fwd_b_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight producers X, M, W, ... and derives X operand forwarding selects, the D load-use
// stall, and a saturating stall-cycle counter. Data-memory busy freezes every tracked stage.
module hazard_forward_unit #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic           clock,
  input  logic           reset,
  hazard_forward_if.slave bus
);
  localparam int unsigned FSEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
  } prod_t;

  // Source operands are only ever consulted for the instruction sitting in X.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } src_t;

  prod_t             stage_q [DEPTH];
  prod_t             stage_d [DEPTH];
  src_t              x_src_q;
  src_t              x_src_d;
  logic [CNT_W-1:0]  stall_cycles_q;
  logic [CNT_W-1:0]  stall_cycles_d;

  logic [FSEL_W-1:0] fwd_a_sel_c;
  logic [FSEL_W-1:0] fwd_b_sel_c;
  logic              hit_rs1_c;
  logic              hit_rs2_c;
  logic              load_use_c;
  logic              stall_c;
  logic              admit_c;
  logic              early_load_fwd_c;

  function automatic logic prod_match(input prod_t p, input logic [REG_AW-1:0] src);
    return p.valid && p.wen && (p.rd != '0) && (p.rd == src);
  endfunction

  // Forward selects: walk oldest to youngest so the youngest producer overwrites.
  always_comb begin
    fwd_a_sel_c = '0;
    fwd_b_sel_c = '0;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (prod_match(stage_q[k], x_src_q.rs1)) fwd_a_sel_c = FSEL_W'(k);
      if (prod_match(stage_q[k], x_src_q.rs2)) fwd_b_sel_c = FSEL_W'(k);
    end
    if (!stage_q[0].valid || !x_src_q.use_rs1) fwd_a_sel_c = '0;
    if (!stage_q[0].valid || !x_src_q.use_rs2) fwd_b_sel_c = '0;
  end

  // Load-use: youngest match inside the latency window decides; a younger non-load shadows a load.
  always_comb begin
    hit_rs1_c = 1'b0;
    hit_rs2_c = 1'b0;
    for (int j = int'(LOAD_LATENCY) - 1; j >= 0; j--) begin
      if (prod_match(stage_q[j], bus.d_rs1)) hit_rs1_c = stage_q[j].is_load;
      if (prod_match(stage_q[j], bus.d_rs2)) hit_rs2_c = stage_q[j].is_load;
    end
    load_use_c = bus.d_valid && ((bus.d_use_rs1 && hit_rs1_c) || (bus.d_use_rs2 && hit_rs2_c));
    stall_c    = (load_use_c && !bus.flush) || bus.dmem_busy;
    admit_c    = bus.d_valid && !bus.flush && !load_use_c;
  end

  always_comb begin
    early_load_fwd_c = 1'b0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      if ((k <= int'(LOAD_LATENCY)) && stage_q[k].is_load &&
          ((fwd_a_sel_c == FSEL_W'(k)) || (fwd_b_sel_c == FSEL_W'(k))))
        early_load_fwd_c = 1'b1;
    end
  end

  always_comb begin
    stage_d        = stage_q;
    x_src_d        = x_src_q;
    stall_cycles_d = stall_cycles_q;
    if (!bus.dmem_busy) begin
      for (int i = int'(DEPTH) - 1; i >= 1; i--) stage_d[i] = stage_q[i-1];
      if (admit_c) begin
        stage_d[0] = prod_t'{valid: 1'b1, rd: bus.d_rd, wen: bus.d_wen, is_load: bus.d_is_load};
        x_src_d    = src_t'{rs1: bus.d_rs1, rs2: bus.d_rs2,
                            use_rs1: bus.d_use_rs1, use_rs2: bus.d_use_rs2};
      end else begin
        stage_d[0] = '0;
        x_src_d    = '0;
      end
    end
    if (stall_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      x_src_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      stage_q        <= stage_d;
      x_src_q        <= x_src_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.x_valid      = stage_q[0].valid;
  assign bus.fwd_a_sel    = fwd_a_sel_c;
  assign bus.fwd_b_sel    = fwd_b_sel_c;
  assign bus.stall_cycles = stall_cycles_q;

  // A load may only reach X through the bypass once its data is available.
  a_no_early_load_fwd: assert property (@(posedge clock) disable iff (!reset) !early_load_fwd_c);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector tables, reset corner cases, and randomized
// traffic compared against an in-flight instruction queue model.
module tb_hazard_forward_unit;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned FSEL_W  = 2;
  localparam int unsigned A_DEPTH = 3;
  localparam int unsigned A_LL    = 1;
  localparam int unsigned A_CNT_W = 32;
  localparam int unsigned B_DEPTH = 4;
  localparam int unsigned B_LL    = 2;
  localparam int unsigned B_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_forward_if #(.REG_AW(REG_AW), .FSEL_W(FSEL_W), .CNT_W(A_CNT_W)) ifa ();
  hazard_forward_if #(.REG_AW(REG_AW), .FSEL_W(FSEL_W), .CNT_W(B_CNT_W)) ifb ();

  hazard_forward_unit #(.DEPTH(A_DEPTH), .REG_AW(REG_AW), .LOAD_LATENCY(A_LL), .CNT_W(A_CNT_W))
    u_dut_a (.clock(clk), .reset(rst_n), .bus(ifa));
  hazard_forward_unit #(.DEPTH(B_DEPTH), .REG_AW(REG_AW), .LOAD_LATENCY(B_LL), .CNT_W(B_CNT_W))
    u_dut_b (.clock(clk), .reset(rst_n), .bus(ifb));

  typedef struct {
    bit v; int rd; bit wen; bit ld; int rs1; int rs2; bit u1; bit u2;
  } instr_t;

  typedef struct {
    instr_t d; bit fl; bit busy;
    int e_stall; int e_xv; int e_fa; int e_fb; int e_cnt;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  vec_t   tbl_a[$];
  vec_t   tbl_b[$];
  instr_t pipe[$];      // pipe[0] is the instruction in X, higher index = older
  longint m_cnt;

  function automatic instr_t nop();
    instr_t i;
    i = '{v: 0, rd: 0, wen: 0, ld: 0, rs1: 0, rs2: 0, u1: 0, u2: 0};
    return i;
  endfunction
  function automatic instr_t alu_i(input int rd, input int rs1);
    instr_t i;
    i = '{v: 1, rd: rd, wen: 1, ld: 0, rs1: rs1, rs2: 0, u1: 1, u2: 0};
    return i;
  endfunction
  function automatic instr_t alu_r(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '{v: 1, rd: rd, wen: 1, ld: 0, rs1: rs1, rs2: rs2, u1: 1, u2: 1};
    return i;
  endfunction
  function automatic instr_t lw(input int rd, input int rs1);
    instr_t i;
    i = '{v: 1, rd: rd, wen: 1, ld: 1, rs1: rs1, rs2: 0, u1: 1, u2: 0};
    return i;
  endfunction
  function automatic vec_t mkv(input instr_t d, input bit fl, input bit busy, input int st,
                               input int xv, input int fa, input int fb, input int cnt);
    vec_t r;
    r.d = d; r.fl = fl; r.busy = busy;
    r.e_stall = st; r.e_xv = xv; r.e_fa = fa; r.e_fb = fb; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input instr_t d, input bit fl, input bit busy);
    if (which == 0) begin
      ifa.d_valid = d.v;    ifa.d_rd = REG_AW'(d.rd);
      ifa.d_rs1 = REG_AW'(d.rs1); ifa.d_rs2 = REG_AW'(d.rs2);
      ifa.d_use_rs1 = d.u1; ifa.d_use_rs2 = d.u2;
      ifa.d_wen = d.wen;    ifa.d_is_load = d.ld;
      ifa.flush = fl;       ifa.dmem_busy = busy;
    end else begin
      ifb.d_valid = d.v;    ifb.d_rd = REG_AW'(d.rd);
      ifb.d_rs1 = REG_AW'(d.rs1); ifb.d_rs2 = REG_AW'(d.rs2);
      ifb.d_use_rs1 = d.u1; ifb.d_use_rs2 = d.u2;
      ifb.d_wen = d.wen;    ifb.d_is_load = d.ld;
      ifb.flush = fl;       ifb.dmem_busy = busy;
    end
  endtask

  task automatic sample(input int which, output int st, output int xv, output int fa,
                        output int fb, output int cnt);
    if (which == 0) begin
      st = int'(ifa.stall); xv = int'(ifa.x_valid);
      fa = int'(ifa.fwd_a_sel); fb = int'(ifa.fwd_b_sel); cnt = int'(ifa.stall_cycles);
    end else begin
      st = int'(ifb.stall); xv = int'(ifb.x_valid);
      fa = int'(ifb.fwd_a_sel); fb = int'(ifb.fwd_b_sel); cnt = int'(ifb.stall_cycles);
    end
  endtask

  task automatic check_all(input int which, input string tag, input int st, input int xv,
                           input int fa, input int fb, input int cnt);
    int a_st, a_xv, a_fa, a_fb, a_cnt;
    sample(which, a_st, a_xv, a_fa, a_fb, a_cnt);
    check({tag, " stall"}, a_st, st);
    check({tag, " x_valid"}, a_xv, xv);
    check({tag, " fwd_a_sel"}, a_fa, fa);
    check({tag, " fwd_b_sel"}, a_fb, fb);
    check({tag, " stall_cycles"}, a_cnt, cnt);
  endtask

  // One cycle: drive after the falling edge, compare mid-low-phase, then let the rising edge commit.
  task automatic run_row(input int which, input string tag, input vec_t r);
    @(negedge clk);
    drive(which, r.d, r.fl, r.busy);
    #2;
    check_all(which, tag, r.e_stall, r.e_xv, r.e_fa, r.e_fb, r.e_cnt);
    @(posedge clk);
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, nop(), 1'b0, 1'b0);
    drive(1, nop(), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int youngest(input int src, input int from);
    for (int k = from; k < pipe.size(); k++)
      if (pipe[k].v && pipe[k].wen && pipe[k].rd != 0 && pipe[k].rd == src) return k;
    return -1;
  endfunction

  function automatic bit src_hazard(input int src, input bit use_src, input int ll);
    int w;
    w = youngest(src, 0);
    return use_src && (w >= 0) && (w < ll) && pipe[w].ld;
  endfunction

  task automatic random_phase(input int which, input int depth, input int ll, input int cnt_w,
                              input int cycles);
    longint cmax;
    cmax = (longint'(1) << cnt_w) - 1;
    reset_all();
    pipe.delete();
    m_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      instr_t d;
      bit fl, busy, lu, m_stall;
      int wa, wb, e_fa, e_fb, e_xv;
      d.v   = ($urandom_range(0, 9) < 8);
      d.rd  = $urandom_range(0, 3);
      d.rs1 = $urandom_range(0, 3);
      d.rs2 = $urandom_range(0, 3);
      d.wen = ($urandom_range(0, 4) != 0);
      d.ld  = ($urandom_range(0, 2) == 0);
      d.u1  = ($urandom_range(0, 4) != 0);
      d.u2  = ($urandom_range(0, 1) != 0);
      fl    = ($urandom_range(0, 9) == 0);
      busy  = ($urandom_range(0, 6) == 0);
      e_xv = 0; e_fa = 0; e_fb = 0;
      if (pipe.size() > 0 && pipe[0].v) begin
        e_xv = 1;
        wa = youngest(pipe[0].rs1, 1);
        wb = youngest(pipe[0].rs2, 1);
        if (pipe[0].u1 && wa > 0) e_fa = wa;
        if (pipe[0].u2 && wb > 0) e_fb = wb;
      end
      lu = d.v && (src_hazard(d.rs1, d.u1, ll) || src_hazard(d.rs2, d.u2, ll));
      m_stall = (lu && !fl) || busy;
      @(negedge clk);
      drive(which, d, fl, busy);
      #2;
      check_all(which, $sformatf("rnd%0d c%0d", which, c), int'(m_stall), e_xv, e_fa, e_fb,
                int'(m_cnt));
      @(posedge clk);
      if (!busy) begin
        pipe.push_front((d.v && !fl && !lu) ? d : nop());
        if (pipe.size() > depth) void'(pipe.pop_back());
      end
      if (m_stall && m_cnt < cmax) m_cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // DEPTH=3, LOAD_LATENCY=1 directed sequence; each row lists the D instruction and the
    // values expected before the following rising edge.
    tbl_a.push_back(mkv(alu_i(5, 0),     0, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mkv(alu_r(6, 5, 5),  0, 0, 0, 1, 0, 0, 0));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 1, 1, 1, 0));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mkv(lw(5, 1),        0, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mkv(alu_r(7, 5, 1),  0, 0, 1, 1, 0, 0, 0));
    tbl_a.push_back(mkv(alu_r(7, 5, 1),  0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 1, 2, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_i(5, 0),     0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_i(5, 0),     0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(alu_r(8, 5, 0),  0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 1, 1, 0, 1));
    tbl_a.push_back(mkv(alu_i(0, 0),     0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_i(0, 0),     0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(alu_r(8, 0, 0),  0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(lw(5, 1),        0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_r(6, 5, 2),  1, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_i(9, 0),     0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(mkv(alu_r(10, 9, 0), 0, 0, 0, 1, 0, 0, 1));
    tbl_a.push_back(mkv(nop(),           0, 1, 1, 1, 1, 0, 1));
    tbl_a.push_back(mkv(lw(11, 9),       1, 1, 1, 1, 1, 0, 2));
    tbl_a.push_back(mkv(nop(),           0, 1, 1, 1, 1, 0, 3));
    tbl_a.push_back(mkv(nop(),           0, 0, 0, 1, 1, 0, 4));
    tbl_a.push_back(mkv(alu_i(9, 0),     0, 0, 0, 0, 0, 0, 4));
    tbl_a.push_back(mkv(alu_r(10, 9, 0), 0, 0, 0, 1, 0, 0, 4));
    tbl_a.push_back(mkv(nop(),           0, 1, 1, 1, 1, 0, 4));

    // DEPTH=4, LOAD_LATENCY=2: a dependent of a load waits two cycles, then bypasses from S[3].
    tbl_b.push_back(mkv(lw(5, 1),        0, 0, 0, 0, 0, 0, 0));
    tbl_b.push_back(mkv(alu_r(6, 5, 2),  0, 0, 1, 1, 0, 0, 0));
    tbl_b.push_back(mkv(alu_r(6, 5, 2),  0, 0, 1, 0, 0, 0, 1));
    tbl_b.push_back(mkv(alu_r(6, 5, 2),  0, 0, 0, 0, 0, 0, 2));
    tbl_b.push_back(mkv(nop(),           0, 0, 0, 1, 3, 0, 2));

    rst_n = 1'b0;
    drive(0, nop(), 1'b0, 1'b0);
    drive(1, nop(), 1'b0, 1'b0);
    #2;
    check_all(0, "reset_a", 0, 0, 0, 0, 0);
    check_all(1, "reset_b", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_row(0, "post_reset_a", mkv(nop(), 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl_a.size(); i++) run_row(0, $sformatf("tbl_a[%0d]", i), tbl_a[i]);

    // Reset pulled while the freeze is still active: state and counter clear at once.
    @(negedge clk);
    drive(0, nop(), 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all(0, "reset_in_freeze", 1, 0, 0, 0, 0);
    drive(0, nop(), 1'b0, 1'b0);
    #1;
    check_all(0, "reset_freeze_released", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_row(0, "after_reset_a", mkv(nop(), 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl_b.size(); i++) run_row(1, $sformatf("tbl_b[%0d]", i), tbl_b[i]);

    random_phase(0, int'(A_DEPTH), int'(A_LL), int'(A_CNT_W), 500);
    random_phase(1, int'(B_DEPTH), int'(B_LL), int'(B_CNT_W), 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
